// File: rtl/wait_state_memory.sv
// Dual-port behavioural memory with independently configurable wait states.
// The instruction port is read-only. The data port supports byte-masked writes.
// Optional console output is enabled by defining WAIT_STATE_MEMORY_CONSOLE_EN.
// When enabled, data writes to the CONSOLE_ADDRESS word emit a byte and do not store.
// Memory contents are never cleared. Preload them at simulation initialisation
// through a hierarchical reference to `mem`.
module wait_state_memory #(
  parameter int unsigned DEPTH_WORDS     = 1048576,
  parameter int unsigned IMEM_LATENCY    = 0,
  parameter int unsigned DMEM_LATENCY    = 2,
  parameter logic [31:0] CONSOLE_ADDRESS = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_enable,
  input  logic        imem_state,
  input  logic [31:0] imem_address,
  output logic [31:0] imem_data,
  output logic        imem_ready,
  input  logic        dmem_enable,
  input  logic        dmem_state,
  input  logic [31:0] dmem_address,
  input  logic [3:0]  dmem_frame_mask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready
`ifdef WAIT_STATE_MEMORY_CONSOLE_EN
  ,
  output logic        console_valid,
  output logic [7:0]  console_data
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic WRITE = 1'b1;
  localparam logic [3:0] ILOAD = (IMEM_LATENCY > 0) ? 4'(IMEM_LATENCY - 1) : 4'd0;
  localparam logic [3:0] DLOAD = (DMEM_LATENCY > 0) ? 4'(DMEM_LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  logic [31:0] mem [DEPTH_WORDS];

  state_e        i_st_q, i_st_d, d_st_q, d_st_d;
  logic [3:0]    i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
  logic [AW-1:0] i_idx_q, i_idx_d, d_idx_q, d_idx_d;
  logic [31:0]   i_data_q, d_rdata_q;
  logic          d_write_q, d_write_d;
  logic [3:0]    d_mask_q, d_mask_d;
  logic [31:0]   d_wdata_q, d_wdata_d;
  logic          d_store;

  // Address bits beyond the wrapped word index and the instruction-port
  // READ/WRITE code have no effect on behaviour.
  logic unused_bits;
  assign unused_bits = ^{imem_state, imem_address, dmem_address, CONSOLE_ADDRESS};

  // Instruction-port next state: accept, count wait states, then complete.
  always_comb begin
    i_st_d  = i_st_q;
    i_cnt_d = i_cnt_q;
    i_idx_d = i_idx_q;
    case (i_st_q)
      StIdle: begin
        if (imem_enable) begin
          i_idx_d = imem_address[AW+1:2];
          if (IMEM_LATENCY == 0) begin
            i_st_d = StDone;
          end else begin
            i_st_d  = StWait;
            i_cnt_d = ILOAD;
          end
        end
      end
      StWait: begin
        if (i_cnt_q == 4'd0) i_st_d = StDone;
        else                 i_cnt_d = i_cnt_q - 4'd1;
      end
      default: i_st_d = StIdle;
    endcase
  end

  // Data-port next state: same sequencing, also latches write controls.
  always_comb begin
    d_st_d    = d_st_q;
    d_cnt_d   = d_cnt_q;
    d_idx_d   = d_idx_q;
    d_write_d = d_write_q;
    d_mask_d  = d_mask_q;
    d_wdata_d = d_wdata_q;
    case (d_st_q)
      StIdle: begin
        if (dmem_enable) begin
          d_idx_d   = dmem_address[AW+1:2];
          d_write_d = (dmem_state == WRITE);
          d_mask_d  = dmem_frame_mask;
          d_wdata_d = dmem_wdata;
          if (DMEM_LATENCY == 0) begin
            d_st_d = StDone;
          end else begin
            d_st_d  = StWait;
            d_cnt_d = DLOAD;
          end
        end
      end
      StWait: begin
        if (d_cnt_q == 4'd0) d_st_d = StDone;
        else                 d_cnt_d = d_cnt_q - 4'd1;
      end
      default: d_st_d = StIdle;
    endcase
  end

  // Read data is live in the DONE cycle and held afterwards.
  always_comb begin
    imem_ready = (i_st_q == StDone);
    dmem_ready = (d_st_q == StDone);
    imem_data  = imem_ready ? mem[i_idx_q] : i_data_q;
    dmem_rdata = (dmem_ready && !d_write_q) ? mem[d_idx_q] : d_rdata_q;
  end

`ifdef WAIT_STATE_MEMORY_CONSOLE_EN
  logic       d_console_q;
  logic [7:0] console_data_q;

  // Console writes are diverted away from memory.
  always_comb begin
    console_valid = dmem_ready && d_write_q && d_console_q;
    console_data  = console_valid ? d_wdata_q[7:0] : console_data_q;
    d_store       = dmem_ready && d_write_q && !d_console_q;
  end

  // Console match flag and held console byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_console_q    <= 1'b0;
      console_data_q <= 8'h00;
    end else begin
      if (d_st_q == StIdle && dmem_enable) begin
        d_console_q <= (dmem_address[31:2] == CONSOLE_ADDRESS[31:2]);
      end
      if (console_valid) console_data_q <= d_wdata_q[7:0];
    end
  end
`else
  // Data-port writes always go to memory.
  always_comb d_store = dmem_ready && d_write_q;
`endif

  // Port state registers and held read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      i_st_q    <= StIdle;
      i_cnt_q   <= 4'd0;
      i_idx_q   <= '0;
      i_data_q  <= 32'h0;
      d_st_q    <= StIdle;
      d_cnt_q   <= 4'd0;
      d_idx_q   <= '0;
      d_write_q <= 1'b0;
      d_mask_q  <= 4'h0;
      d_wdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      i_st_q    <= i_st_d;
      i_cnt_q   <= i_cnt_d;
      i_idx_q   <= i_idx_d;
      d_st_q    <= d_st_d;
      d_cnt_q   <= d_cnt_d;
      d_idx_q   <= d_idx_d;
      d_write_q <= d_write_d;
      d_mask_q  <= d_mask_d;
      d_wdata_q <= d_wdata_d;
      if (imem_ready) i_data_q <= imem_data;
      if (dmem_ready && !d_write_q) d_rdata_q <= dmem_rdata;
    end
  end

  // Byte-lane write commit at the end of DONE. Reset aborts it, but the
  // array itself is never cleared. mask[3] selects the least significant byte.
  always_ff @(posedge clk) begin
    if (reset && d_store) begin
      if (d_mask_q[3]) mem[d_idx_q][7:0]   <= d_wdata_q[7:0];
      if (d_mask_q[2]) mem[d_idx_q][15:8]  <= d_wdata_q[15:8];
      if (d_mask_q[1]) mem[d_idx_q][23:16] <= d_wdata_q[23:16];
      if (d_mask_q[0]) mem[d_idx_q][31:24] <= d_wdata_q[31:24];
    end
  end

endmodule

// File: doc/wait_state_memory.md
WAIT_STATE_MEMORY -- requirements
Module: wait_state_memory

Interface
REQ-001 Parameters SHALL be: DEPTH_WORDS, default 1048576, word count, power of two; IMEM_LATENCY, default 0, instruction-port wait cycles, range 0..15; DMEM_LATENCY, default 2, data-port wait cycles, range 0..15; CONSOLE_ADDRESS, default 32'h1000_0000, byte-output address.
REQ-002 Ports SHALL be (name direction width meaning): clk input 1 clock; reset input 1 synchronous active-low reset.
REQ-003 imem_enable input 1 request strobe; imem_state input 1 READ/WRITE code (instruction port accepts READ only); imem_address input 32 byte address; imem_data output 32 read word; imem_ready output 1 completion pulse.
REQ-004 dmem_enable input 1 request strobe; dmem_state input 1 READ/WRITE code; dmem_address input 32 byte address; dmem_frame_mask input 4 byte enables; dmem_wdata input 32 write word; dmem_rdata output 32 read word; dmem_ready output 1 completion pulse.
REQ-005 console_valid output 1 byte strobe; console_data output 8 console byte (present only per REQ-021).

Function
REQ-006 Each port SHALL run an independent FSM with states IDLE, WAIT, DONE.
REQ-007 In IDLE, enable=1 at a rising edge SHALL accept the request, latching address, state, mask and write data; go to WAIT if latency>0, else DONE.
REQ-008 WAIT SHALL load a counter with latency-1 on entry, decrement each cycle, go to DONE when counter = 0.
REQ-009 DONE SHALL last exactly one cycle with ready=1, perform the access in that cycle, then return to IDLE.
REQ-010 Ready SHALL therefore rise latency+1 cycles after the accepting edge; back-to-back requests SHALL be accepted in the cycle after DONE (IDLE entered, not skipped).
REQ-011 Enable or input changes during WAIT/DONE SHALL be ignored; an accepted request always completes.
REQ-012 Word index SHALL be address[31:2] modulo DEPTH_WORDS; address[1:0] ignored; out-of-range addresses wrap.
REQ-013 Read data SHALL appear on imem_data/dmem_rdata in the DONE cycle and be held until the next DONE; outputs are 0 before the first read.
REQ-014 Writes SHALL commit at the end of DONE with byte lanes: mask[3]->[7:0], mask[2]->[15:8], mask[1]->[23:16], mask[0]->[31:24]; mask 0000 SHALL leave memory unchanged but still pulse ready.
REQ-015 An instruction-port WRITE request SHALL complete as a read of the addressed word (no store).
REQ-016 Simultaneous DONE on both ports to the same word: instruction read SHALL return pre-write data; data write SHALL commit.
REQ-017 Simultaneous data READ and instruction READ SHALL both be served in the same cycle.
REQ-018 Initial memory contents SHALL be loadable by hex file via simulation initialisation; no reset clears memory.

Reset
REQ-019 reset=0 at a rising edge SHALL force both FSMs to IDLE, counters to 0, imem_ready=0, dmem_ready=0, imem_data=0, dmem_rdata=0, console_valid=0, console_data=0.
REQ-020 Reset during WAIT or DONE SHALL abort the request; a pending write SHALL NOT commit; memory contents SHALL be preserved.

Configuration
REQ-021 Macro WAIT_STATE_MEMORY_CONSOLE_EN defined: a data WRITE with word address equal to CONSOLE_ADDRESS[31:2] SHALL NOT store; in its DONE cycle console_valid=1 for one cycle and console_data=dmem_wdata[7:0]; console_data held until next console write.
REQ-022 Macro undefined: console ports SHALL be absent and CONSOLE_ADDRESS SHALL be ordinary (wrapped) memory.

Verification
REQ-023 DMEM_LATENCY=2, write 32'hDEAD_BEEF mask 1111 to 0x40 -> dmem_ready high exactly 3 cycles after accept; subsequent read of 0x40 returns 32'hDEAD_BEEF.
REQ-024 Word 0x40 = 32'h1122_3344, write 32'hAABB_CCDD mask 1000 -> read returns 32'h1122_33DD; mask 0000 -> unchanged, ready still pulses.
REQ-025 IMEM_LATENCY=0, enable held high -> one read every 2 cycles, imem_ready alternating 1/0, data tracks address.
REQ-026 Same-word data write 32'h5555_5555 and instruction read completing same cycle (old 32'h0) -> imem_data=0, later read =32'h5555_5555.
REQ-027 Reset asserted in WAIT of a write to 0x80 -> ready never pulses, word at 0x80 unchanged, all outputs 0.
REQ-028 CONSOLE_EN defined, write 32'h0000_0041 to 32'h1000_0000 -> console_valid one cycle with console_data=8'h41, memory word unchanged; undefined -> word stores 32'h0000_0041.
